serial_alu_sequencer: RTL and testbench

//  Bit-serial 32-bit ALU built around the one-bit ALU slice function: latches two

---
 rtl/serial_alu_sequencer_if.sv | 15 +
 rtl/serial_alu_sequencer.sv | 75 +++++++
 tb/tb_serial_alu_sequencer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/serial_alu_sequencer_if.sv
// serial_alu_sequencer_if: operand/op request and result bundle of the serial ALU
interface serial_alu_sequencer_if #(parameter int WIDTH = 32) ();
  logic start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0] op;
  logic busy;
  logic done;
  logic [WIDTH-1:0] result;
  logic carryout;
  logic overflow;
  logic zero;
  modport master (output start, a, b, op, input busy, done, result, carryout, overflow, zero);
  modport slave (input start, a, b, op, output busy, done, result, carryout, overflow, zero);
endinterface

// File: rtl/serial_alu_sequencer.sv
// serial_alu_sequencer: bit-serial ALU, one slice per clock, LSB first into the result MSB
module serial_alu_sequencer #(parameter int WIDTH = 32) (
  input logic clk,
  input logic reset,
  serial_alu_sequencer_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_XOR = 3'd2, OP_SLT = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4, OP_NAND = 3'd5, OP_NOR = 3'd6;
  typedef enum logic [1:0] {IDLE, RUN, SLTFIX, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] a_r, b_r, result, result_n;
  logic [2:0] op_r;
  logic carry, carryout, overflow, zero, sum_msb;
  logic ai, bi, bb, sum, cout, inv, arith, bit_v, accept;
  always_comb begin
    inv = op_r == OP_SUB || op_r == OP_SLT;
    arith = inv || op_r == OP_ADD;
    ai = a_r[cnt];
    bi = b_r[cnt];
    bb = bi ^ inv;
    sum = ai ^ bb ^ carry;
    cout = (ai & bb) | (ai & carry) | (bb & carry);
    bit_v = arith ? sum : op_r == OP_XOR ? ai ^ bi : op_r == OP_AND ? ai & bi :
            op_r == OP_NAND ? ~(ai & bi) : op_r == OP_NOR ? ~(ai | bi) : ai | bi;
    accept = bus.start && (state == IDLE || state == DONE);
    state_n = accept ? RUN : state == DONE ? IDLE : state == SLTFIX ? DONE :
              (state == RUN && cnt == LAST) ? (op_r == OP_SLT ? SLTFIX : DONE) : state;
    // SLT collapses to the corrected sign of a-b once the subtraction has run
    result_n = state == RUN ? {bit_v, result[WIDTH-1:1]} :
               state == SLTFIX ? {{(WIDTH-1){1'b0}}, sum_msb ^ overflow} : result;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      carry <= 1'b0;
      result <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
      zero <= 1'b0;
      sum_msb <= 1'b0;
      a_r <= '0;
      b_r <= '0;
      op_r <= '0;
    end else begin
      state <= state_n;
      result <= result_n;
      if (state_n == DONE) zero <= result_n == '0;
      if (accept) begin
        a_r <= bus.a;
        b_r <= bus.b;
        op_r <= bus.op;
        cnt <= '0;
        carry <= bus.op == OP_SUB || bus.op == OP_SLT;
      end else if (state == RUN) begin
        cnt <= cnt + 1'b1;
        if (arith) carry <= cout;
        if (cnt == LAST) begin
          sum_msb <= sum;
          overflow <= arith & (carry ^ cout);
          carryout <= cout & (op_r == OP_ADD || op_r == OP_SUB);
        end
      end
    end
  end
  assign bus.busy = state == RUN || state == SLTFIX;
  assign bus.done = state == DONE;
  assign bus.result = result;
  assign bus.carryout = carryout;
  assign bus.overflow = overflow;
  assign bus.zero = zero;
endmodule

// File: tb/tb_serial_alu_sequencer.sv
// tb_serial_alu_sequencer: directed vectors with a queue scoreboard checked on every done
module tb_serial_alu_sequencer;
  localparam int W = 32;
  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, XOR = 3'd2, SLT = 3'd3;
  localparam logic [2:0] AND = 3'd4, NAND = 3'd5, NOR = 3'd6, OR = 3'd7;
  typedef struct {
    logic [W-1:0] res;
    logic co;
    logic ov;
    logic z;
    int start;
    int lat;
  } exp_t;
  logic clk, reset;
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  exp_t q[$];
  serial_alu_sequencer_if #(.WIDTH(W)) bus ();
  serial_alu_sequencer #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (bus.done) begin
      if (q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("result", 64'(bus.result), 64'(e.res));
        chk("carryout", 64'(bus.carryout), 64'(e.co));
        chk("overflow", 64'(bus.overflow), 64'(e.ov));
        chk("zero", 64'(bus.zero), 64'(e.z));
        chk("latency", 64'(cyc - e.start), 64'(e.lat));
      end
    end
  end
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] r, input logic co, input logic ov, input int glitch);
    exp_t e;
    e.res = r;
    e.co = co;
    e.ov = ov;
    e.z = r == '0;
    e.start = cyc + 1;
    e.lat = o == SLT ? W + 1 : W;
    q.push_back(e);
    bus.start = 1'b1;
    bus.a = x;
    bus.b = y;
    bus.op = o;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = ~x;
    bus.b = ~y;
    bus.op = ~o;
    chk("busy", 64'(bus.busy), 64'd1);
    for (int k = 1; k < 80 && !bus.done; k++) begin
      bus.start = k == glitch;
      if (k == glitch) begin
        bus.a = '1;
        bus.b = '1;
        bus.op = SUB;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    if (!bus.done) chk("done_timeout", 64'd0, 64'd1);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.op = ADD;
    repeat (2) @(negedge clk);
    chk("reset_flags", 64'({bus.busy, bus.done, bus.carryout, bus.overflow, bus.zero}), 64'd0);
    chk("reset_result", 64'(bus.result), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    run_op(ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, -1);
    @(negedge clk);
    run_op(SUB, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1, -1);
    @(negedge clk);
    run_op(SLT, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, -1);
    run_op(SLT, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 1'b1, -1);
    @(negedge clk);
    run_op(NAND, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FFF0FFF, 1'b0, 1'b0, -1);
    run_op(NOR, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, -1);
    @(negedge clk);
    run_op(XOR, 32'h12345678, 32'hFFFF0000, 32'hEDCB5678, 1'b0, 1'b0, -1);
    @(negedge clk);
    run_op(AND, 32'h12345678, 32'h0F0F0F0F, 32'h02040608, 1'b0, 1'b0, -1);
    @(negedge clk);
    run_op(OR, 32'h12340000, 32'h00005678, 32'h12345678, 1'b0, 1'b0, -1);
    @(negedge clk);
    run_op(ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, -1);
    @(negedge clk);
    run_op(SUB, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, -1);
    @(negedge clk);
    run_op(SUB, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0, 1'b0, -1);
    @(negedge clk);
    run_op(SLT, 32'h00000003, 32'h00000005, 32'h00000001, 1'b0, 1'b0, -1);
    @(negedge clk);
    run_op(ADD, 32'h00000010, 32'h00000020, 32'h00000030, 1'b0, 1'b0, 6);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 32'h1;
    bus.b = 32'h2;
    bus.op = ADD;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy_done", 64'({bus.busy, bus.done}), 64'd0);
    chk("abort_result", 64'(bus.result), 64'd0);
    repeat (40) @(negedge clk);
    run_op(ADD, 32'h00000003, 32'h00000004, 32'h00000007, 1'b0, 1'b0, -1);
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
